// File: rtl/mac_output_accumulator.sv
`default_nettype none
// mac_output_accumulator: accumulates super_MAC partial sums per output pixel, then
// rescales, saturates and buffers each result behind a credit-protected FIFO. Rev 1.0
module mac_output_accumulator #(
  parameter int IN_WIDTH    = 32,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_SCALE   = 8,
  parameter int MAC_LATENCY = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 issue_valid,
  input  logic                 issue_first,
  input  logic                 issue_last,
  input  logic [IN_WIDTH-1:0]  mac_in,
  output logic                 issue_allow,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 overflow_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + MAC_LATENCY + 1);
  localparam int HI_W  = ACC_WIDTH - OUT_WIDTH + 1;

  logic [MAC_LATENCY-1:0] vld_pipe;
  logic [MAC_LATENCY-1:0] first_pipe;
  logic [MAC_LATENCY-1:0] last_pipe;
  logic                   d_valid;
  logic                   d_first;
  logic                   d_last;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] mac_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] scaled;
  logic [HI_W-1:0]             scaled_hi;
  logic [OUT_WIDTH-1:0]        sat;

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     inflight_last;
  logic                 push_req;
  logic                 push;
  logic                 pop;
  logic                 full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Issue tags travel alongside the MAC pipeline so they line up with mac_in.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      vld_pipe[0]   <= issue_valid;
      first_pipe[0] <= issue_first;
      last_pipe[0]  <= issue_last;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

  assign d_valid = vld_pipe[MAC_LATENCY-1];
  assign d_first = first_pipe[MAC_LATENCY-1];
  assign d_last  = last_pipe[MAC_LATENCY-1];

  assign mac_ext   = ACC_WIDTH'($signed(mac_in));
  assign acc_next  = d_first ? mac_ext : acc + mac_ext;
  assign scaled    = acc_next >>> OUT_SCALE;
  assign scaled_hi = scaled[ACC_WIDTH-1:OUT_WIDTH-1];

  // Result fits when all bits above the output sign bit replicate it.
  always_comb begin
    sat = scaled[OUT_WIDTH-1:0];
    if (!((&scaled_hi) || !(|scaled_hi))) begin
      sat = scaled[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      acc <= '0;
    end else if (d_valid) begin
      acc <= acc_next;
    end
  end

  assign push_req = d_valid & d_last;
  assign pop      = out_valid & out_ready;
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign push     = push_req & (!full | pop);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // Every pixel-closing group still in the MAC pipe already owns a FIFO slot.
  always_comb begin
    inflight_last = '0;
    for (int i = 0; i < MAC_LATENCY; i++) begin
      inflight_last = inflight_last + CNT_W'(vld_pipe[i] & last_pipe[i]);
    end
  end

  assign issue_allow = (count + inflight_last) < CNT_W'(FIFO_DEPTH);

endmodule
`default_nettype wire

// File: tb/tb_mac_output_accumulator.sv
`default_nettype none
// tb_mac_output_accumulator: directed vectors and corner sequences for mac_output_accumulator.
module tb_mac_output_accumulator;

  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        issue_valid;
  logic        issue_first;
  logic        issue_last;
  logic [31:0] mac_in;
  logic        issue_allow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        overflow_err;

  logic [31:0] issue_mac;
  logic [31:0] mac_pipe [3];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] mac;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  // Upstream MAC model: the value tied to an issue appears 3 cycles later.
  always @(posedge clk) begin
    mac_pipe[0] <= issue_mac;
    mac_pipe[1] <= mac_pipe[0];
    mac_pipe[2] <= mac_pipe[1];
  end
  assign mac_in = mac_pipe[2];

  mac_output_accumulator dut (
    .clk          (clk),
    .arst_n_in    (arst_n_in),
    .issue_valid  (issue_valid),
    .issue_first  (issue_first),
    .issue_last   (issue_last),
    .mac_in       (mac_in),
    .issue_allow  (issue_allow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .overflow_err (overflow_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic l, input logic [31:0] m);
    issue_valid = v;
    issue_first = f;
    issue_last  = l;
    issue_mac   = m;
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic pop_expect(input string name, input logic [15:0] exp);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(name, {16'd0, out_data}, {16'd0, exp});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Issues four single-group pixels back to back from an empty FIFO and lets them land.
  task automatic fill4(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b1, (base + 32'(k)) << 8);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (6) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] got [$];
    int issued;
    bit drop_pending;

    vecs[0] = '{32'h0000_1200, 16'h0012};
    vecs[1] = '{32'h7FFF_0000, 16'h7FFF};
    vecs[2] = '{32'h8000_0000, 16'h8000};
    vecs[3] = '{32'hFFFF_FF00, 16'hFFFF};
    vecs[4] = '{32'h0000_0300, 16'h0003};
    vecs[5] = '{32'h0000_0080, 16'h0000};
    vecs[6] = '{32'hFFFF_8000, 16'hFF80};

    arst_n_in = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_overflow", {31'd0, overflow_err}, 32'd0);
    chk("rst_issue_allow", {31'd0, issue_allow}, 32'd1);
    arst_n_in = 1'b1;
    step();
    chk("post_rst_issue_allow", {31'd0, issue_allow}, 32'd1);

    // Single-group pixels: latency of 4 cycles, rescale and saturation.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b1, vecs[i].mac);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      repeat (2) step();
      chk($sformatf("vec%0d_early_valid", i), {31'd0, out_valid}, 32'd0);
      step();
      pop_expect($sformatf("vec%0d_data", i), vecs[i].exp);
      chk($sformatf("vec%0d_popped", i), {31'd0, out_valid}, 32'd0);
    end

    // Three-group pixel: 256 + 512 - 1024 = -256 -> -1.
    drive(1'b1, 1'b1, 1'b0, 32'd256);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'd512);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FC00);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk("grp3_no_out_a", {31'd0, out_valid}, 32'd0);
    step();
    chk("grp3_no_out_b", {31'd0, out_valid}, 32'd0);
    step();
    pop_expect("grp3_data", 16'hFFFF);
    chk("grp3_single_result", {31'd0, out_valid}, 32'd0);

    // Backpressure with credit-gated issue, then drain.
    issued = 0;
    drop_pending = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (drop_pending) begin
        chk("bp_allow_drop", {31'd0, issue_allow}, 32'd0);
        drop_pending = 1'b0;
      end
      if (cyc == 9) begin
        chk("bp_full_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_full_allow", {31'd0, issue_allow}, 32'd0);
      end
      out_ready = (cyc >= 10);
      if (out_valid && out_ready) got.push_back(out_data);
      if (issue_allow && issued < 6) begin
        drive(1'b1, 1'b1, 1'b1, 32'(issued + 1) << 8);
        issued++;
        if (issued == 4) drop_pending = 1'b1;
      end else begin
        drive(1'b0, 1'b0, 1'b0, 32'd0);
      end
      step();
    end
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    chk("bp_count", 32'(got.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp_order%0d", k), (k < got.size()) ? {16'd0, got[k]} : 32'hDEAD,
          32'(k + 1));
    end
    chk("bp_overflow", {31'd0, overflow_err}, 32'd0);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Push lands in the same cycle as a pop while full.
    fill4(32'd10);
    chk("pp_full_allow", {31'd0, issue_allow}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'd20 << 8);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) step();
    chk("pp_head", {16'd0, out_data}, 32'd10);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_overflow", {31'd0, overflow_err}, 32'd0);
    chk("pp_still_full", {31'd0, issue_allow}, 32'd0);
    pop_expect("pp_q0", 16'd11);
    pop_expect("pp_q1", 16'd12);
    pop_expect("pp_q2", 16'd13);
    pop_expect("pp_tail", 16'd20);
    chk("pp_empty", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a pixel with a result already buffered.
    drive(1'b1, 1'b1, 1'b1, 32'h500);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (4) step();
    chk("mr_pre_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h100);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h100);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    arst_n_in = 1'b0;
    #1;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out_data", {16'd0, out_data}, 32'd0);
    chk("mr_overflow", {31'd0, overflow_err}, 32'd0);
    chk("mr_issue_allow", {31'd0, issue_allow}, 32'd1);
    step();
    arst_n_in = 1'b1;
    repeat (4) step();
    chk("mr_no_partial", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h300);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    wait_out_valid("mr_after");
    pop_expect("mr_after_data", 16'h0003);

    // Forced issue into a full FIFO with no pop.
    fill4(32'd1);
    chk("ov_full_allow", {31'd0, issue_allow}, 32'd0);
    chk("ov_pre", {31'd0, overflow_err}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h900);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (4) step();
    chk("ov_set", {31'd0, overflow_err}, 32'd1);
    repeat (3) step();
    chk("ov_sticky", {31'd0, overflow_err}, 32'd1);
    pop_expect("ov_q0", 16'd1);
    pop_expect("ov_q1", 16'd2);
    pop_expect("ov_q2", 16'd3);
    pop_expect("ov_q3", 16'd4);
    chk("ov_no_extra", {31'd0, out_valid}, 32'd0);
    chk("ov_sticky_end", {31'd0, overflow_err}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
